bomb_scheduler: RTL
===================

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 8, total bomb slots shared by both players.
REQ-002 Parameter FUSE_TICKS, default 6'd48, i_tick pulses from placement to expiry.
REQ-003 clk  in  1  system clock, all state on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_tick  in  1  one-cycle fuse decrement strobe.
REQ-006 i_p1_place / i_p2_place  in  1  placement request, level, sampled each cycle.
REQ-007 i_p1_cor / i_p2_cor  in  8  requested grid cell index (0..255).
REQ-008 i_p1_cap / i_p2_cap  in  3  per-player bomb capacity from gadget block.
REQ-009 i_p1_len / i_p2_len  in  2  per-player flame length from gadget block.
REQ-010 i_chain  in  256  cells currently under flame.
REQ-011 o_p1_ack / o_p2_ack  out  1  placement accepted, one-cycle pulse.
REQ-012 o_bomb_grid  out  256  bit n set = live bomb on cell n.
REQ-013 o_p1_active / o_p2_active  out  3  live bombs owned per player.
REQ-014 o_exp_valid  out  1; i_exp_ready  in  1; o_exp_cor  out  8; o_exp_len  out  2; o_exp_owner  out  1 (0=p1, 1=p2)  explosion event stream.

Function
REQ-015 Each slot SHALL be in FREE, ARMED or FIRING; slot holds cor, len, owner, 6-bit fuse.
REQ-016 Request SHALL be accepted iff: active count < cap, o_bomb_grid[cor]==0, and a FREE slot is available to it.
REQ-017 Accepted request SHALL load lowest-index FREE slot: ARMED, fuse=FUSE_TICKS, len snapshot of i_pN_len, set grid bit, increment active count, pulse ack -- all visible the cycle after the request.
REQ-018 Both players requesting same cell, or only one FREE slot available: one winner by round-robin pointer (reset: p1); pointer SHALL flip to loser only after a contested grant.
REQ-019 Both accepted, different cells, >=2 FREE slots: both granted; p1 takes lower slot.
REQ-020 ARMED fuse SHALL decrement by 1 per i_tick; on i_tick at fuse==1 slot SHALL become FIRING next cycle (no wrap).
REQ-021 ARMED slot with i_chain[cor]==1 SHALL become FIRING next cycle regardless of fuse.
REQ-022 o_exp_valid SHALL be high whenever any slot is FIRING; o_exp_* reflect lowest-index FIRING slot, registered, held stable until handshake.
REQ-023 On o_exp_valid && i_exp_ready, the presented slot SHALL be FREE, its grid bit cleared and owner count decremented the next cycle; max one event per cycle.
REQ-024 Slot freed in cycle N SHALL NOT be grantable before cycle N+1; acceptance uses registered grid and counts only.
REQ-025 Cap dropping below active count SHALL block new placements only; live bombs unaffected.
REQ-026 Active counts SHALL never exceed NUM_SLOTS nor underflow.

Reset
REQ-027 rst SHALL force all slots FREE, fuses 0, o_bomb_grid=0, active counts 0, acks 0, o_exp_valid 0, o_exp_cor/len/owner 0, pointer p1.
REQ-028 rst mid-operation SHALL discard all pending bombs and unhandshaked events without emitting.

Configuration
REQ-029 Macro BOMB_CHAIN_EN defined: REQ-021 active. Undefined: i_chain ignored, expiry only by fuse.

Verification
REQ-030 p1 places at cor 17, cap 1, len 2 -> o_p1_ack next cycle, grid[17]=1, o_p1_active=1; 48 ticks later o_exp_valid, cor 17, len 2, owner 0.
REQ-031 p1 and p2 request cor 40 same cycle twice (ack/explode between) -> first grant p1, second grant p2.
REQ-032 p1 cap 1 with one live bomb, requests cor 50 -> no ack, grid[50]=0.
REQ-033 Two bombs expire same tick, i_exp_ready low 3 cycles -> valid held, lower slot presented stable; ready high -> two events on consecutive cycles, then valid 0.
REQ-034 BOMB_CHAIN_EN, bomb at 33 fuse 20, i_chain[33]=1 -> FIRING next cycle; without macro -> no change.
REQ-035 rst asserted while valid high -> all outputs 0 immediately, no event after release.

Source files
------------

// File: rtl/bomb_scheduler.sv
// Shared bomb slot pool for two players: placement arbitration, fuse countdown and explosion event stream.
// Define BOMB_CHAIN_EN to let cells under flame detonate armed bombs early; otherwise i_chain is ignored.
module bomb_scheduler #(
    parameter int         NUM_SLOTS  = 8,
    parameter logic [5:0] FUSE_TICKS = 6'd48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick,
    input  logic         i_p1_place,
    input  logic         i_p2_place,
    input  logic [7:0]   i_p1_cor,
    input  logic [7:0]   i_p2_cor,
    input  logic [2:0]   i_p1_cap,
    input  logic [2:0]   i_p2_cap,
    input  logic [1:0]   i_p1_len,
    input  logic [1:0]   i_p2_len,
    input  logic [255:0] i_chain,
    output logic         o_p1_ack,
    output logic         o_p2_ack,
    output logic [255:0] o_bomb_grid,
    output logic [2:0]   o_p1_active,
    output logic [2:0]   o_p2_active,
    output logic         o_exp_valid,
    input  logic         i_exp_ready,
    output logic [7:0]   o_exp_cor,
    output logic [1:0]   o_exp_len,
    output logic         o_exp_owner
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_ARMED  = 2'd1,
        S_FIRING = 2'd2
    } slot_state_t;

    slot_state_t    state_q [NUM_SLOTS];
    slot_state_t    state_d [NUM_SLOTS];
    logic [7:0]     cor_q   [NUM_SLOTS];
    logic [7:0]     cor_d   [NUM_SLOTS];
    logic [1:0]     len_q   [NUM_SLOTS];
    logic [1:0]     len_d   [NUM_SLOTS];
    logic           owner_q [NUM_SLOTS];
    logic           owner_d [NUM_SLOTS];
    logic [5:0]     fuse_q  [NUM_SLOTS];
    logic [5:0]     fuse_d  [NUM_SLOTS];

    logic [255:0]   grid_q, grid_d;
    logic [2:0]     p1_cnt_q, p1_cnt_d;
    logic [2:0]     p2_cnt_q, p2_cnt_d;
    logic           ptr_q, ptr_d;
    logic           p1_ack_q, p2_ack_q;

    logic           exp_valid_q, exp_valid_d;
    logic [7:0]     exp_cor_q, exp_cor_d;
    logic [1:0]     exp_len_q, exp_len_d;
    logic           exp_owner_q, exp_owner_d;
    logic [SW-1:0]  exp_slot_q, exp_slot_d;
    logic           exp_found;

    logic [NUM_SLOTS-1:0] free_mask;
    logic [NUM_SLOTS-1:0] chain_hit;
    logic           free_any, free_two;
    logic [SW-1:0]  free0, free1;
    logic           p1_ok, p2_ok, contested;
    logic           p1_grant, p2_grant;
    logic [SW-1:0]  p1_slot, p2_slot;
    logic           hs;
    logic           p1_dec, p2_dec;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign free_mask[gi] = (state_q[gi] == S_FREE);
`ifdef BOMB_CHAIN_EN
        assign chain_hit[gi] = (state_q[gi] == S_ARMED) && i_chain[cor_q[gi]];
`else
        assign chain_hit[gi] = 1'b0;
`endif
    end

`ifndef BOMB_CHAIN_EN
    logic chain_unused;
    assign chain_unused = ^i_chain;
`endif

    // Two lowest free slots, so both players can be served in one cycle.
    always_comb begin
        free_any = 1'b0;
        free_two = 1'b0;
        free0    = '0;
        free1    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (free_mask[i]) begin
                if (!free_any) begin
                    free0    = SW'(i);
                    free_any = 1'b1;
                end else if (!free_two) begin
                    free1    = SW'(i);
                    free_two = 1'b1;
                end
            end
        end
    end

    always_comb begin
        p1_ok     = i_p1_place && (p1_cnt_q < i_p1_cap) && !grid_q[i_p1_cor] && free_any;
        p2_ok     = i_p2_place && (p2_cnt_q < i_p2_cap) && !grid_q[i_p2_cor] && free_any;
        contested = p1_ok && p2_ok && ((i_p1_cor == i_p2_cor) || !free_two);
        p1_grant  = p1_ok && (!contested || !ptr_q);
        p2_grant  = p2_ok && (!contested || ptr_q);
        p1_slot   = free0;
        p2_slot   = p1_grant ? free1 : free0;
        ptr_d     = contested ? p1_grant : ptr_q;
        hs        = exp_valid_q && i_exp_ready;
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            cor_d[i]   = cor_q[i];
            len_d[i]   = len_q[i];
            owner_d[i] = owner_q[i];
            fuse_d[i]  = fuse_q[i];
            if (state_q[i] == S_ARMED) begin
                if (i_tick) begin
                    if (fuse_q[i] <= 6'd1) begin
                        state_d[i] = S_FIRING;
                        fuse_d[i]  = 6'd0;
                    end else begin
                        fuse_d[i]  = fuse_q[i] - 6'd1;
                    end
                end
                if (chain_hit[i]) begin
                    state_d[i] = S_FIRING;
                    fuse_d[i]  = 6'd0;
                end
            end
            if (hs && (exp_slot_q == SW'(i))) begin
                state_d[i] = S_FREE;
                fuse_d[i]  = 6'd0;
            end
            if (p1_grant && (p1_slot == SW'(i))) begin
                state_d[i] = S_ARMED;
                cor_d[i]   = i_p1_cor;
                len_d[i]   = i_p1_len;
                owner_d[i] = 1'b0;
                fuse_d[i]  = FUSE_TICKS;
            end
            if (p2_grant && (p2_slot == SW'(i))) begin
                state_d[i] = S_ARMED;
                cor_d[i]   = i_p2_cor;
                len_d[i]   = i_p2_len;
                owner_d[i] = 1'b1;
                fuse_d[i]  = FUSE_TICKS;
            end
        end
    end

    always_comb begin
        grid_d = grid_q;
        if (hs) begin
            grid_d[exp_cor_q] = 1'b0;
        end
        if (p1_grant) begin
            grid_d[i_p1_cor] = 1'b1;
        end
        if (p2_grant) begin
            grid_d[i_p2_cor] = 1'b1;
        end
        p1_dec   = hs && !exp_owner_q && (p1_cnt_q != 3'd0);
        p2_dec   = hs && exp_owner_q && (p2_cnt_q != 3'd0);
        p1_cnt_d = p1_cnt_q + 3'(p1_grant) - 3'(p1_dec);
        p2_cnt_d = p2_cnt_q + 3'(p2_grant) - 3'(p2_dec);
    end

    // Event is chosen from next-state so valid rises the same cycle a slot starts firing
    // and the following slot is presented right after a handshake.
    always_comb begin
        exp_valid_d = exp_valid_q;
        exp_cor_d   = exp_cor_q;
        exp_len_d   = exp_len_q;
        exp_owner_d = exp_owner_q;
        exp_slot_d  = exp_slot_q;
        exp_found   = 1'b0;
        if (!exp_valid_q || i_exp_ready) begin
            exp_valid_d = 1'b0;
            exp_cor_d   = 8'd0;
            exp_len_d   = 2'd0;
            exp_owner_d = 1'b0;
            exp_slot_d  = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!exp_found && (state_d[i] == S_FIRING)) begin
                    exp_found   = 1'b1;
                    exp_valid_d = 1'b1;
                    exp_cor_d   = cor_d[i];
                    exp_len_d   = len_d[i];
                    exp_owner_d = owner_d[i];
                    exp_slot_d  = SW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= S_FREE;
                cor_q[i]   <= 8'd0;
                len_q[i]   <= 2'd0;
                owner_q[i] <= 1'b0;
                fuse_q[i]  <= 6'd0;
            end
            grid_q      <= '0;
            p1_cnt_q    <= 3'd0;
            p2_cnt_q    <= 3'd0;
            ptr_q       <= 1'b0;
            p1_ack_q    <= 1'b0;
            p2_ack_q    <= 1'b0;
            exp_valid_q <= 1'b0;
            exp_cor_q   <= 8'd0;
            exp_len_q   <= 2'd0;
            exp_owner_q <= 1'b0;
            exp_slot_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                cor_q[i]   <= cor_d[i];
                len_q[i]   <= len_d[i];
                owner_q[i] <= owner_d[i];
                fuse_q[i]  <= fuse_d[i];
            end
            grid_q      <= grid_d;
            p1_cnt_q    <= p1_cnt_d;
            p2_cnt_q    <= p2_cnt_d;
            ptr_q       <= ptr_d;
            p1_ack_q    <= p1_grant;
            p2_ack_q    <= p2_grant;
            exp_valid_q <= exp_valid_d;
            exp_cor_q   <= exp_cor_d;
            exp_len_q   <= exp_len_d;
            exp_owner_q <= exp_owner_d;
            exp_slot_q  <= exp_slot_d;
        end
    end

    assign o_p1_ack    = p1_ack_q;
    assign o_p2_ack    = p2_ack_q;
    assign o_bomb_grid = grid_q;
    assign o_p1_active = p1_cnt_q;
    assign o_p2_active = p2_cnt_q;
    assign o_exp_valid = exp_valid_q;
    assign o_exp_cor   = exp_cor_q;
    assign o_exp_len   = exp_len_q;
    assign o_exp_owner = exp_owner_q;

endmodule
